mem_bank_write_arbiter: RTL and testbench
=========================================

// Module: mem_bank_write_arbiter
// PURPOSE
//  Owns the write side of one mem_multi_bank_reset instance. Sequences the power-up and on-demand
//  memory clear (reset_mem / reset_mem_done_pulse), then shares the single write port between
//  two requesters: port 0 (FM operator state writeback, high priority) and port 1 (host register
//  writes, low priority, with a starvation guard). Sits directly in front of the bank memory.
// PARAMETERS
//  DATA_WIDTH  16                  width of write data
//  DEPTH       512                 words per bank (power of 2, >=2)
//  NUM_BANKS   2                   number of banks (>=2)
//  BANK_WIDTH  $clog2(NUM_BANKS)   bank select width (derived, do not override)
//  MAX_WAIT    4                   cycles port 1 may be blocked before it takes priority (>=1)
// PORTS
//  clk            in   1                 clock
//  reset          in   1                 synchronous, active-high
//  clear_req      in   1                 request a full memory re-clear (level, sampled in RUN)
//  v0/v1          in   1                 write request valid, port 0 / port 1
//  r0/r1          out  1                 write request ready, port 0 / port 1 (combinational)
//  bank0/bank1    in   BANK_WIDTH        target bank, per port
//  addr0/addr1    in   $clog2(DEPTH)     target word address, per port
//  data0/data1    in   DATA_WIDTH        write data, per port
//  mem_wea        out  1                 to memory wea (registered)
//  mem_banka      out  BANK_WIDTH        to memory banka (registered)
//  mem_addra      out  $clog2(DEPTH)     to memory addra (registered)
//  mem_dia        out  DATA_WIDTH        to memory dia (registered)
//  mem_reset_mem  out  1                 to memory reset_mem (registered, 1-cycle pulse)
//  mem_clear_done in   1                 from memory reset_mem_done_pulse
//  busy           out  1                 1 while state != RUN
//  init_done      out  1                 sticky 1 after first clear completes; 0 on reset
// BEHAVIOUR
//  Reset: state=INIT, all mem_* outputs 0, wait counter 0, init_done 0, busy 1, r0=r1=0.
//  FSM: INIT -> CLEAR (unconditional, 1 cycle); mem_reset_mem registers 1 on the INIT->CLEAR
//   and RUN->CLEAR transitions, so it is high exactly in the first CLEAR cycle.
//   CLEAR -> RUN when mem_clear_done==1 (ignored in the first CLEAR cycle); init_done<=1.
//   RUN -> CLEAR when clear_req==1. clear_req in INIT/CLEAR is ignored (no queuing).
//  No timeout in CLEAR; the memory guarantees completion in NUM_BANKS*DEPTH cycles.
//  Handshake: transfer on vN&&rN in cycle N; mem_wea/banka/addra/dia show it in cycle N+1
//   (1-cycle latency). At most one transfer per cycle. mem_wea=0 on non-transfer cycles;
//   banka/addra/dia hold their last value when mem_wea=0.
//  Readiness: r0=r1=0 outside RUN and in any RUN cycle with clear_req==1 (clear wins over
//   simultaneous requests). Otherwise: prio1 = (wait==MAX_WAIT);
//   r0 = !(prio1 && v1); r1 = prio1 || !v0. rN may be 1 while vN==0 (value ignored).
//  Wait counter: in RUN, if v1 && !r1 -> wait+1 (saturates at MAX_WAIT); on a port-1 transfer
//   or when v1==0 -> 0. Width $clog2(MAX_WAIT+1). Cleared on entry to CLEAR.
//  Ordering: a transfer in the cycle before clear_req reaches memory one cycle before
//   mem_reset_mem rises, so it is written then erased; no write is issued during CLEAR.
//  Reset mid-clear or mid-write: immediate return to INIT, pending registered write dropped
//   (mem_wea=0), a fresh clear is sequenced; memory is reset by the same reset.
// TESTING
//  Params DW=16,DEPTH=8,NB=4,MAX_WAIT=4, memory model attached.
//  1 Release reset -> mem_reset_mem=1 in cycle 2 only; busy=1 until done pulse (~32 cycles
//    later), then busy=0, init_done=1; readback of all 32 words = DEFAULT_VALUE.
//  2 RUN, v0=1 bank0=2 addr0=5 data0=16'hBEEF one cycle -> next cycle mem_wea=1, banka=2,
//    addra=5, dia=16'hBEEF; readback bank2/addr5 = 16'hBEEF.
//  3 v0 and v1 held high continuously -> port 0 granted 4 cycles, port 1 granted 5th cycle,
//    pattern repeats 4:1; no cycle with two grants or none.
//  4 RUN, clear_req=1 with v0=v1=1 same cycle -> r0=r1=0, no mem_wea next cycle, busy=1,
//    mem_reset_mem pulse, all words cleared, previously written 16'hBEEF gone.
//  5 Assert reset 10 cycles into CLEAR -> outputs return to reset values, new reset_mem
//    pulse issued, init_done stays 0 until the new clear completes.

Source files
------------

// File: rtl/mem_bank_write_arbiter.sv
// mem_bank_write_arbiter: sequences bank memory clears and arbitrates two write ports with a starvation guard
module mem_bank_write_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 512,
  parameter int NUM_BANKS  = 2,
  parameter int BANK_WIDTH = $clog2(NUM_BANKS),
  parameter int MAX_WAIT   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_req,
  input  logic                     v0,
  input  logic                     v1,
  output logic                     r0,
  output logic                     r1,
  input  logic [BANK_WIDTH-1:0]    bank0,
  input  logic [BANK_WIDTH-1:0]    bank1,
  input  logic [$clog2(DEPTH)-1:0] addr0,
  input  logic [$clog2(DEPTH)-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    data0,
  input  logic [DATA_WIDTH-1:0]    data1,
  output logic                     mem_wea,
  output logic [BANK_WIDTH-1:0]    mem_banka,
  output logic [$clog2(DEPTH)-1:0] mem_addra,
  output logic [DATA_WIDTH-1:0]    mem_dia,
  output logic                     mem_reset_mem,
  input  logic                     mem_clear_done,
  output logic                     busy,
  output logic                     init_done
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {INIT, CLEAR, RUN} state_t;
  state_t state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic run_ok, prio1, t0, t1;
  assign busy = state != RUN;
  always_comb begin
    run_ok = state == RUN && !clear_req;
    prio1 = wait_cnt == WW'(MAX_WAIT);
    r0 = run_ok && !(prio1 && v1);
    r1 = run_ok && (prio1 || !v0);
    t0 = v0 && r0;
    t1 = v1 && r1;
    wait_nxt = (run_ok && v1 && !r1) ? wait_cnt + WW'(1) : '0;
    // mem_reset_mem is high only in the first CLEAR cycle, masking a stale done pulse there
    state_nxt = state == INIT ? CLEAR :
                state == CLEAR ? ((mem_clear_done && !mem_reset_mem) ? RUN : CLEAR) :
                (clear_req ? CLEAR : RUN);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      wait_cnt <= '0;
      mem_wea <= 1'b0;
      mem_banka <= '0;
      mem_addra <= '0;
      mem_dia <= '0;
      mem_reset_mem <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state <= state_nxt;
      wait_cnt <= wait_nxt;
      mem_wea <= t0 || t1;
      mem_reset_mem <= state_nxt == CLEAR && state != CLEAR;
      if (state == CLEAR && state_nxt == RUN) init_done <= 1'b1;
      if (t0 || t1) begin
        mem_banka <= t1 ? bank1 : bank0;
        mem_addra <= t1 ? addr1 : addr0;
        mem_dia <= t1 ? data1 : data0;
      end
    end
  end
endmodule

// File: tb/tb_mem_bank_write_arbiter.sv
// tb_mem_bank_write_arbiter: directed and random checks of clear sequencing and write arbitration
module tb_mem_bank_write_arbiter;
  localparam int DW = 16, DEPTH = 8, NB = 4, MW = 4, WORDS = NB * DEPTH;
  localparam logic [15:0] DEF = 16'hA5A5;
  logic clk = 0, reset = 1, clear_req = 0, v0 = 0, v1 = 0;
  logic r0, r1, mem_wea, mem_reset_mem, mem_clear_done, busy, init_done;
  logic [1:0] bank0 = 0, bank1 = 0, mem_banka;
  logic [2:0] addr0 = 0, addr1 = 0, mem_addra;
  logic [15:0] data0 = 0, data1 = 0, mem_dia;
  int checks = 0, errors = 0, n;
  always #5 clk = ~clk;
  mem_bank_write_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_BANKS(NB), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .v0(v0), .v1(v1), .r0(r0), .r1(r1),
    .bank0(bank0), .bank1(bank1), .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
    .mem_wea(mem_wea), .mem_banka(mem_banka), .mem_addra(mem_addra), .mem_dia(mem_dia),
    .mem_reset_mem(mem_reset_mem), .mem_clear_done(mem_clear_done), .busy(busy), .init_done(init_done));
  // bank memory: one word cleared per cycle after reset_mem, then a done pulse
  logic [15:0] mem [WORDS];
  logic clearing;
  logic [4:0] ccnt;
  always @(posedge clk) begin
    if (reset) begin
      clearing <= 0;
      ccnt <= 0;
      mem_clear_done <= 0;
    end else begin
      mem_clear_done <= 0;
      if (mem_reset_mem) begin
        clearing <= 1;
        ccnt <= 0;
      end else if (clearing) begin
        mem[ccnt] <= DEF;
        ccnt <= ccnt + 1;
        if (ccnt == 5'(WORDS - 1)) begin
          clearing <= 0;
          mem_clear_done <= 1;
        end
      end
      if (mem_wea && !clearing) mem[{mem_banka, mem_addra}] <= mem_dia;
    end
  end
  logic [15:0] exp_mem [WORDS];
  logic m_wea, e0, e1, t0, t1, prio;
  logic [1:0] m_bank;
  logic [2:0] m_addr;
  logic [15:0] m_data;
  int blocked;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_idle(input logic exp_id, output int cnt);
    cnt = 0;
    while (busy !== 1'b0 && cnt < 200) begin
      chk("init_done_in_clear", init_done, exp_id);
      @(negedge clk);
      cnt++;
    end
    chk("clear_timeout", cnt < 200, 1);
  endtask
  task automatic readback(input string tag);
    for (int i = 0; i < WORDS; i++) chk(tag, mem[i], exp_mem[i]);
  endtask
  // one RUN cycle: check last cycle's write, drive, check readiness, advance the model
  task automatic step(input logic a, input logic b, input logic [1:0] b0, input logic [2:0] a0,
                      input logic [15:0] d0, input logic [1:0] b1, input logic [2:0] a1, input logic [15:0] d1);
    @(negedge clk);
    chk("wea", mem_wea, m_wea);
    chk("banka", mem_banka, m_bank);
    chk("addra", mem_addra, m_addr);
    chk("dia", mem_dia, m_data);
    v0 = a; v1 = b; bank0 = b0; addr0 = a0; data0 = d0; bank1 = b1; addr1 = a1; data1 = d1;
    #1;
    prio = blocked >= MW;
    e0 = !(prio && b);
    e1 = prio || !a;
    chk("r0", r0, e0);
    chk("r1", r1, e1);
    t0 = a && e0;
    t1 = b && e1;
    m_wea = t0 || t1;
    if (t0) begin m_bank = b0; m_addr = a0; m_data = d0; exp_mem[{b0, a0}] = d0; end
    if (t1) begin m_bank = b1; m_addr = a1; m_data = d1; exp_mem[{b1, a1}] = d1; end
    blocked = (b && !t1) ? blocked + 1 : 0;
  endtask
  initial begin
    v0 = 1; v1 = 1;
    repeat (3) @(negedge clk);
    chk("rst_wea", mem_wea, 0);
    chk("rst_reset_mem", mem_reset_mem, 0);
    chk("rst_busy", busy, 1);
    chk("rst_init_done", init_done, 0);
    chk("rst_r0", r0, 0);
    chk("rst_r1", r1, 0);
    chk("rst_banka", mem_banka, 0);
    chk("rst_dia", mem_dia, 0);
    // test 1: power-up clear
    reset = 0; v0 = 0; v1 = 0;
    #1 chk("init_reset_mem", mem_reset_mem, 0);
    @(negedge clk);
    chk("pulse_hi", mem_reset_mem, 1);
    chk("clear_busy", busy, 1);
    @(negedge clk);
    chk("pulse_lo", mem_reset_mem, 0);
    wait_idle(0, n);
    chk("clear_len", n >= WORDS - 2 && n <= WORDS + 4, 1);
    chk("init_done_set", init_done, 1);
    for (int i = 0; i < WORDS; i++) exp_mem[i] = DEF;
    readback("init_readback");
    m_wea = 0; m_bank = 0; m_addr = 0; m_data = 0; blocked = 0;
    // test 2: single port-0 write
    step(1, 0, 2, 5, 16'hBEEF, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("beef_written", mem[{2'd2, 3'd5}], 16'hBEEF);
    // test 3: both ports saturated -> 4:1 pattern
    for (int i = 0; i < 15; i++) begin
      step(1, 1, 2'($urandom), 3'($urandom), 16'($urandom), 2'($urandom), 3'($urandom), 16'($urandom));
      chk("ratio_r1", r1, (i % 5) == 4);
      chk("ratio_r0", r0, (i % 5) != 4);
    end
    // random traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom), 16'($urandom),
           2'($urandom), 3'($urandom), 16'($urandom));
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    readback("random_readback");
    // test 4: write then clear with simultaneous requests
    step(1, 0, 2, 5, 16'hBEEF, 0, 0, 0);
    @(negedge clk);
    chk("pre_clear_wea", mem_wea, 1);
    clear_req = 1; v0 = 1; v1 = 1;
    #1 chk("clear_r0", r0, 0);
    chk("clear_r1", r1, 0);
    @(negedge clk);
    chk("clear_no_wea", mem_wea, 0);
    chk("clear_pulse", mem_reset_mem, 1);
    chk("clear_busy2", busy, 1);
    chk("beef_before_erase", mem[{2'd2, 3'd5}], 16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("clear_req_ignored", mem_reset_mem, 0);
      chk("no_wea_in_clear", mem_wea, 0);
      chk("clear_r0_in_clear", r0, 0);
    end
    clear_req = 0; v0 = 0; v1 = 0;
    wait_idle(1, n);
    for (int i = 0; i < WORDS; i++) exp_mem[i] = DEF;
    readback("reclear_readback");
    m_wea = 0; blocked = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // test 5: reset in the middle of a clear
    @(negedge clk);
    clear_req = 1;
    @(negedge clk);
    clear_req = 0;
    repeat (10) @(negedge clk);
    reset = 1; v0 = 1;
    @(negedge clk);
    chk("mid_rst_wea", mem_wea, 0);
    chk("mid_rst_pulse", mem_reset_mem, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_init_done", init_done, 0);
    chk("mid_rst_r0", r0, 0);
    reset = 0; v0 = 0;
    #1 chk("mid_init_pulse", mem_reset_mem, 0);
    @(negedge clk);
    chk("mid_pulse_hi", mem_reset_mem, 1);
    @(negedge clk);
    chk("mid_pulse_lo", mem_reset_mem, 0);
    wait_idle(0, n);
    chk("mid_clear_len", n >= WORDS - 2 && n <= WORDS + 4, 1);
    chk("mid_init_done", init_done, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
